// File: rtl/pipeline_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// pipeline_ctrl_pkg
//   Shared types and constants for the 5-stage core pipeline controller.
//   Contents:
//     STALL_W                      width of the per-stage stall vector
//     STALL_NONE/ID/EX/MEM         stall vectors, bit k = hold stage k
//                                  ([0]pc [1]if [2]id [3]ex [4]mem [5]wb)
//     ctrl_state_e                 controller FSM states (RUN, FLUSH)
//     stall_encode()               priority merge of stall requests
// ---------------------------------------------------------------------------
package pipeline_ctrl_pkg;

  localparam int STALL_W = 6;

  // Each request freezes its own stage and everything upstream. The first
  // zero above the ones becomes the bubble stage.
  localparam logic [STALL_W-1:0] STALL_NONE = 6'b000000;
  localparam logic [STALL_W-1:0] STALL_ID   = 6'b000111;
  localparam logic [STALL_W-1:0] STALL_EX   = 6'b001111;
  localparam logic [STALL_W-1:0] STALL_MEM  = 6'b011111;

  typedef enum logic {
    CTRL_RUN   = 1'b0,
    CTRL_FLUSH = 1'b1
  } ctrl_state_e;

  // The deepest requesting stage wins. Its vector is a superset of the
  // vectors of all shallower stages.
  function automatic logic [STALL_W-1:0] stall_encode(
    input logic req_id,
    input logic req_ex,
    input logic req_mem
  );
    logic [STALL_W-1:0] v;
    v = STALL_NONE;
    if (req_mem) begin
      v = STALL_MEM;
    end else if (req_ex) begin
      v = STALL_EX;
    end else if (req_id) begin
      v = STALL_ID;
    end
    return v;
  endfunction

endpackage

// File: rtl/pipeline_ctrl_stall_watchdog.sv
// ---------------------------------------------------------------------------
// pipeline_ctrl_stall_watchdog  (stall watchdog)
//   Counts consecutive stalled cycles. It raises a sticky flag once the count
//   has reached STALL_TIMEOUT.
//   Parameters:
//     CNT_W          counter width
//     STALL_TIMEOUT  consecutive stalled cycles that set the flag (fits CNT_W)
//   Ports:
//     clk        in  core clock
//     rst_n      in  asynchronous active-low reset
//     i_stalled  in  1 when any stage is held this cycle
//     i_clr      in  clears the sticky flag (wins over a same-cycle set)
//     o_timeout  out sticky timeout flag
// ---------------------------------------------------------------------------
module pipeline_ctrl_stall_watchdog #(
  parameter int CNT_W         = 8,
  parameter int STALL_TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_stalled,
  input  logic i_clr,
  output logic o_timeout
);

  localparam logic [CNT_W-1:0] LP_LIMIT = CNT_W'(STALL_TIMEOUT);

  logic [CNT_W-1:0] r_cnt;
  logic             r_timeout;
  logic             w_at_limit;

  assign w_at_limit = (r_cnt == LP_LIMIT);

  // The counter saturates at the limit, so a long stall cannot wrap it back
  // below the threshold. Any stall-free cycle restarts the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (!i_stalled) begin
      r_cnt <= '0;
    end else if (!w_at_limit) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // The flag sets one edge after the count reaches the limit. Software
  // clearing takes priority over a simultaneous set. The counter itself is
  // left alone, so a stall that is still saturated sets the flag again.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_timeout <= 1'b0;
    end else if (i_clr) begin
      r_timeout <= 1'b0;
    end else if (w_at_limit) begin
      r_timeout <= 1'b1;
    end
  end

  assign o_timeout = r_timeout;

endmodule

// File: rtl/pipeline_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_ctrl
//   Central pipeline control for the 5-stage core.
//   - Merges ID/EX/MEM stall requests into the 6-bit stall vector.
//   - Sequences exception flushes as one registered flush cycle carrying
//     the handler PC.
//   - Watchdog flags a pipeline stuck in stall.
//   Optional feature macro: STALL_PERF_CNT_EN adds the 32-bit performance
//   counters perf_stall_id/ex/mem and perf_flush.
//   Parameters:
//     ADDR_W         PC width
//     CNT_W          watchdog counter width
//     STALL_TIMEOUT  consecutive stalled cycles that set stall_timeout
//   Ports:
//     clk            in   core clock
//     rst            in   asynchronous active-low reset
//     stallreq_id    in   load-use bubble request
//     stallreq_ex    in   multi-cycle EX busy
//     stallreq_mem   in   MEM waiting on data bus
//     exc_req        in   MEM committing exception/eret this cycle
//     exc_new_pc     in   handler / EPC target
//     timeout_clr    in   clears sticky stall_timeout
//     stall          out  [0]pc [1]if [2]id [3]ex [4]mem [5]wb, 1 = hold
//     flush          out  kill all inter-stage registers
//     new_pc         out  PC to load while flush=1
//     stall_timeout  out  sticky watchdog flag
//     perf_*         out  (STALL_PERF_CNT_EN only) event counters
// ---------------------------------------------------------------------------
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int ADDR_W        = 32,
  parameter int CNT_W         = 8,
  parameter int STALL_TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stallreq_id,
  input  logic               stallreq_ex,
  input  logic               stallreq_mem,
  input  logic               exc_req,
  input  logic [ADDR_W-1:0]  exc_new_pc,
  input  logic               timeout_clr,
  output logic [STALL_W-1:0] stall,
  output logic               flush,
  output logic [ADDR_W-1:0]  new_pc,
  output logic               stall_timeout
`ifdef STALL_PERF_CNT_EN
  ,
  output logic [31:0]        perf_stall_id,
  output logic [31:0]        perf_stall_ex,
  output logic [31:0]        perf_stall_mem,
  output logic [31:0]        perf_flush
`endif
);

  ctrl_state_e        r_state;
  ctrl_state_e        w_state_nxt;
  logic [ADDR_W-1:0]  r_new_pc;
  logic [STALL_W-1:0] w_stall;
  logic               w_flush;
  logic               w_capture;

  // A flush is only started from RUN. While the flush cycle is in progress,
  // the exception that caused it may still be visible, so exc_req is ignored
  // in FLUSH.
  assign w_capture = (r_state == CTRL_RUN) && exc_req;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= CTRL_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      CTRL_RUN:   if (exc_req) w_state_nxt = CTRL_FLUSH;
      CTRL_FLUSH: w_state_nxt = CTRL_RUN;
      default:    w_state_nxt = CTRL_RUN;
    endcase
  end

  // Output logic. Stall requests are not acted on in two cases: during the
  // cycle an exception commits, and during the flush cycle. Holding stages
  // in those cycles would preserve instructions that are about to be killed.
  // The stall vector is also forced to zero while reset is asserted, because
  // the request inputs may still be active then.
  always_comb begin
    w_stall = STALL_NONE;
    w_flush = 1'b0;
    if (rst) begin
      case (r_state)
        CTRL_RUN: begin
          if (!exc_req) begin
            w_stall = stall_encode(stallreq_id, stallreq_ex, stallreq_mem);
          end
        end
        CTRL_FLUSH: w_flush = 1'b1;
        default:    w_flush = 1'b0;
      endcase
    end
  end

  // The handler PC is captured as the FSM enters FLUSH. It holds between
  // flushes; its value matters only while flush=1.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_new_pc <= '0;
    end else if (w_capture) begin
      r_new_pc <= exc_new_pc;
    end
  end

  assign stall  = w_stall;
  assign flush  = w_flush;
  assign new_pc = r_new_pc;

  pipeline_ctrl_stall_watchdog #(
    .CNT_W         (CNT_W),
    .STALL_TIMEOUT (STALL_TIMEOUT)
  ) u_stall_watchdog (
    .clk       (clk),
    .rst_n     (rst),
    .i_stalled (|w_stall),
    .i_clr     (timeout_clr),
    .o_timeout (stall_timeout)
  );

`ifdef STALL_PERF_CNT_EN
  logic [31:0] r_perf_id;
  logic [31:0] r_perf_ex;
  logic [31:0] r_perf_mem;
  logic [31:0] r_perf_flush;

  // The winning source is read back from the final stall vector. Cycles in
  // which requests are suppressed are therefore not charged to any source.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_perf_id    <= '0;
      r_perf_ex    <= '0;
      r_perf_mem   <= '0;
      r_perf_flush <= '0;
    end else begin
      if (w_stall == STALL_ID)  r_perf_id    <= r_perf_id + 32'd1;
      if (w_stall == STALL_EX)  r_perf_ex    <= r_perf_ex + 32'd1;
      if (w_stall == STALL_MEM) r_perf_mem   <= r_perf_mem + 32'd1;
      if (w_flush)              r_perf_flush <= r_perf_flush + 32'd1;
    end
  end

  assign perf_stall_id  = r_perf_id;
  assign perf_stall_ex  = r_perf_ex;
  assign perf_stall_mem = r_perf_mem;
  assign perf_flush     = r_perf_flush;
`endif

endmodule
